pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter NSTAGE, 6, stall/flush vector width; bit 0 holds PC, bit j freezes pipeline stage j.
REQ-002 Parameter NREQ, 3, number of stall request sources.
REQ-003 Parameter LVLW, 3, width of one stage-level field.
REQ-004 Parameter REQ_LVL, {3'd1,3'd2,3'd3}, packed NREQ*LVLW levels; source i stalls bits 0..REQ_LVL[i].
REQ-005 Parameter DRAIN_CYC, 2, cycles PC/IF stay held after a flush (1..15).
REQ-006 Parameter TIMEOUT, 255, consecutive stalled cycles before the watchdog fires (1..65535).
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rst  input  1  reset: synchronous, active-high.
REQ-009 stall_req  input  NREQ  per-source stall request, level-sensitive.
REQ-010 flush_req  input  1  exception/redirect flush request, single-cycle pulse.
REQ-011 flush_lvl  input  LVLW  highest stage index to flush.
REQ-012 stall  output  NSTAGE  freeze vector.
REQ-013 flush  output  NSTAGE  squash vector.
REQ-014 bubble  output  NSTAGE  bubble-insert vector.
REQ-015 busy  output  1  high while the FSM is not IDLE.
REQ-016 stall_timeout  output  1  sticky watchdog flag.
REQ-017 stall_cycles  output  32  saturating count of cycles with stall != 0.

Function
REQ-018 The FSM SHALL have three states: IDLE, FLUSH and DRAIN.
REQ-019 IDLE -> FLUSH on flush_req; FLUSH -> DRAIN after exactly 1 cycle; DRAIN -> IDLE after DRAIN_CYC cycles.
REQ-020 A flush_req in FLUSH or DRAIN SHALL re-enter FLUSH, latch the new flush_lvl and restart the drain count.
REQ-021 flush_lvl SHALL be registered on the cycle flush_req is accepted; flush SHALL be asserted the following cycle (latency 1).
REQ-022 In FLUSH: flush[j] = 1 for j in 1..latched level, bit 0 = 0; stall SHALL be all-zero regardless of stall_req.
REQ-023 Outside FLUSH, flush SHALL be all-zero.
REQ-024 Stall level L = max REQ_LVL[i] over asserted stall_req[i]; stall[j] = 1 for j <= L; with no request active, stall = 0 (combinational, zero latency).
REQ-025 In DRAIN: stall[1:0] forced to 1, OR-ed with the REQ-024 vector.
REQ-026 Any level >= NSTAGE SHALL saturate to NSTAGE-1.
REQ-027 bubble[j] = stall[j-1] & ~stall[j] for j >= 1; bubble[0] = 0.
REQ-028 busy = (state != IDLE).
REQ-029 The watchdog counter SHALL increment each cycle stall != 0 and clear on any cycle stall == 0.
REQ-030 stall_timeout SHALL set the cycle the watchdog count reaches TIMEOUT and hold until rst; the counter saturates at TIMEOUT.
REQ-031 stall_cycles SHALL increment on every cycle stall != 0 and saturate at 32'hFFFFFFFF.
REQ-032 Simultaneous flush_req and stall_req: flush takes priority; stall requests are ignored for the FLUSH cycle only.

Reset
REQ-033 On rst: state IDLE; drain counter, watchdog counter, latched level, stall_cycles = 0; stall_timeout = 0.
REQ-034 During rst: stall, flush and bubble = 0 and busy = 0, regardless of other inputs.
REQ-035 rst asserted mid-FLUSH or mid-DRAIN SHALL abort to IDLE on the next edge with no residual flush or stall.

Verification
REQ-036 Defaults; stall_req=3'b100 -> stall=6'b001111, bubble=6'b010000; stall_req=3'b010 -> stall=6'b000111.
REQ-037 stall_req=3'b111 -> stall=6'b001111 (max wins); stall_req=0 -> stall=0, bubble=0.
REQ-038 flush_req pulse with flush_lvl=4 at cycle t -> t+1: flush=6'b011110, stall=0, busy=1; t+2..t+3: stall=6'b000011; t+4: busy=0.
REQ-039 Second flush_req during DRAIN -> FLUSH repeats the next cycle and the drain restarts for a full DRAIN_CYC; flush_req together with stall_req=3'b100 -> flush wins for that cycle.
REQ-040 TIMEOUT=4, stall_req held 10 cycles -> stall_timeout rises on the 4th stalled cycle and stays high after release; stall_cycles=10.
REQ-041 rst during DRAIN -> next cycle busy=0, stall=0, stall_cycles=0, stall_timeout=0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: merges per-source stall levels, sequences flush/drain
// after a redirect, and keeps a stall watchdog plus a saturating stall-cycle counter.
module pipe_ctrl #(
   parameter int                    NSTAGE    = 6,
   parameter int                    NREQ      = 3,
   parameter int                    LVLW      = 3,
   parameter logic [NREQ*LVLW-1:0]  REQ_LVL   = {3'd1, 3'd2, 3'd3},
   parameter int                    DRAIN_CYC = 2,
   parameter int                    TIMEOUT   = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   stall_req,
   input  logic              flush_req,
   input  logic [LVLW-1:0]   flush_lvl,
   output logic [NSTAGE-1:0] stall,
   output logic [NSTAGE-1:0] flush,
   output logic [NSTAGE-1:0] bubble,
   output logic              busy,
   output logic              stall_timeout,
   output logic [31:0]       stall_cycles
);

   typedef enum logic [1:0] {IDLE, FLUSH, DRAIN} state_t;

   state_t            state;
   logic [3:0]        drain_cnt;
   logic [LVLW-1:0]   lvl_q;
   logic [15:0]       wd_cnt;
   logic [LVLW-1:0]   max_lvl;
   logic              req_any;
   logic [NSTAGE-1:0] req_vec;
   logic [NSTAGE-1:0] flush_vec;

   localparam logic [NSTAGE-1:0] DRAIN_HOLD = {{(NSTAGE-2){1'b0}}, 2'b11};
   localparam logic [15:0]       TO_LIMIT   = 16'(TIMEOUT);

   // Bits 0..lvl set, with the level clamped to the last stage.
   function automatic logic [NSTAGE-1:0] upto_mask(input logic [LVLW-1:0] lvl);
      logic [NSTAGE-1:0] m;
      int                l;
      l = (int'(lvl) >= NSTAGE) ? NSTAGE - 1 : int'(lvl);
      for (int j = 0; j < NSTAGE; j++) m[j] = (j <= l);
      return m;
   endfunction

   // The leftmost REQ_LVL field belongs to source 0.
   always_comb begin
      max_lvl = '0;
      req_any = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (stall_req[i]) begin
            req_any = 1'b1;
            if (REQ_LVL[(NREQ-1-i)*LVLW +: LVLW] > max_lvl)
               max_lvl = REQ_LVL[(NREQ-1-i)*LVLW +: LVLW];
         end
      end
      req_vec      = req_any ? upto_mask(max_lvl) : '0;
      flush_vec    = upto_mask(lvl_q);
      flush_vec[0] = 1'b0;
   end

   always_comb begin
      stall = '0;
      flush = '0;
      if (!rst) begin
         case (state)
            IDLE:    stall = req_vec;
            FLUSH:   flush = flush_vec;
            DRAIN:   stall = req_vec | DRAIN_HOLD;
            default: stall = '0;
         endcase
      end
   end

   assign bubble = (stall << 1) & ~stall;
   assign busy   = !rst && (state != IDLE);

   // A new flush request from any state re-enters FLUSH and restarts the drain.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         drain_cnt     <= '0;
         lvl_q         <= '0;
         wd_cnt        <= '0;
         stall_timeout <= 1'b0;
         stall_cycles  <= '0;
      end else begin
         if (flush_req) begin
            state <= FLUSH;
            lvl_q <= flush_lvl;
         end else begin
            case (state)
               FLUSH: begin
                  state     <= DRAIN;
                  drain_cnt <= 4'(DRAIN_CYC - 1);
               end
               DRAIN: begin
                  if (drain_cnt == 4'd0) state <= IDLE;
                  else                   drain_cnt <= drain_cnt - 4'd1;
               end
               default: state <= IDLE;
            endcase
         end

         if (|stall) begin
            if (wd_cnt != TO_LIMIT) begin
               wd_cnt <= wd_cnt + 16'd1;
               if (wd_cnt == TO_LIMIT - 16'd1) stall_timeout <= 1'b1;
            end
            if (stall_cycles != 32'hFFFF_FFFF) stall_cycles <= stall_cycles + 32'd1;
         end else begin
            wd_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed plus randomized bench for pipe_ctrl, checked against a cycle-age based
// behavioural model; the watchdog limit is shortened to 4 to reach the sticky flag.
module tb_pipe_ctrl;

   localparam int NSTAGE    = 6;
   localparam int DRAIN_CYC = 2;
   localparam int TO        = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] stall_req;
   logic       flush_req;
   logic [2:0] flush_lvl;
   logic [5:0] stall, flush, bubble;
   logic       busy, stall_timeout;
   logic [31:0] stall_cycles;

   int checks = 0;
   int errors = 0;

   // Model: age 0 = idle, 1 = flushing, 2..1+DRAIN_CYC = draining.
   int     m_age;
   int     m_lvl;
   int     m_run;
   bit     m_to;
   longint m_cyc;
   int     req_lvl[3] = '{1, 2, 3};

   pipe_ctrl #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .stall_req(stall_req), .flush_req(flush_req),
      .flush_lvl(flush_lvl), .stall(stall), .flush(flush), .bubble(bubble),
      .busy(busy), .stall_timeout(stall_timeout), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] ones_upto(input int l);
      int c;
      if (l < 0) return 6'd0;
      c = (l > NSTAGE - 1) ? NSTAGE - 1 : l;
      return 6'((1 << (c + 1)) - 1);
   endfunction

   function automatic logic [5:0] exp_stall();
      int L;
      logic [5:0] s;
      if (rst || m_age == 1) return 6'd0;
      L = -1;
      for (int i = 0; i < 3; i++)
         if (stall_req[i] && req_lvl[i] > L) L = req_lvl[i];
      s = ones_upto(L);
      if (m_age >= 2) s = s | 6'b000011;
      return s;
   endfunction

   function automatic logic [5:0] exp_flush();
      if (rst || m_age != 1) return 6'd0;
      return ones_upto(m_lvl) & 6'b111110;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic [2:0] sr, input logic fr,
                                input logic [2:0] fl);
      rst       = r;
      stall_req = sr;
      flush_req = fr;
      flush_lvl = fl;
      #1;
   endtask

   task automatic checkOutput();
      logic [5:0] s;
      s = exp_stall();
      chk("stall", 32'(stall), 32'(s));
      chk("flush", 32'(flush), 32'(exp_flush()));
      chk("bubble", 32'(bubble), 32'((s << 1) & ~s));
      chk("busy", 32'(busy), 32'(!rst && m_age > 0));
      chk("stall_timeout", 32'(stall_timeout), 32'(m_to));
      chk("stall_cycles", 32'(stall_cycles), 32'(m_cyc));
   endtask

   // Advance one clock and evolve the model using the inputs held across that edge.
   task automatic tick();
      logic [5:0] s;
      s = exp_stall();
      @(posedge clk);
      if (rst) begin
         m_age = 0; m_lvl = 0; m_run = 0; m_to = 0; m_cyc = 0;
      end else begin
         if (s != 0) begin
            if (m_run < TO) m_run++;
            if (m_run == TO) m_to = 1;
            if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
         end else begin
            m_run = 0;
         end
         if (flush_req) begin
            m_age = 1;
            m_lvl = int'(flush_lvl);
         end else if (m_age > 0) begin
            m_age = (m_age >= 1 + DRAIN_CYC) ? 0 : m_age + 1;
         end
      end
      #1;
   endtask

   initial begin
      m_age = 0; m_lvl = 0; m_run = 0; m_to = 0; m_cyc = 0;

      // Reset dominates every other input.
      applyStimulus(1'b1, 3'b111, 1'b1, 3'd4);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      tick(); tick();
      checkOutput();

      // Stall level merging.
      applyStimulus(1'b0, 3'b100, 1'b0, 3'd0);
      chk("lvl3_stall", 32'(stall), 32'h0F);
      chk("lvl3_bubble", 32'(bubble), 32'h10);
      checkOutput(); tick();
      applyStimulus(1'b0, 3'b010, 1'b0, 3'd0);
      chk("lvl2_stall", 32'(stall), 32'h07);
      checkOutput(); tick();
      applyStimulus(1'b0, 3'b111, 1'b0, 3'd0);
      chk("max_stall", 32'(stall), 32'h0F);
      checkOutput(); tick();
      applyStimulus(1'b0, 3'b000, 1'b0, 3'd0);
      chk("none_stall", 32'(stall), 32'd0);
      chk("none_bubble", 32'(bubble), 32'd0);
      checkOutput(); tick();

      // Single flush at level 4 followed by the drain window.
      applyStimulus(1'b0, 3'b000, 1'b1, 3'd4);
      checkOutput(); tick();
      applyStimulus(1'b0, 3'b000, 1'b0, 3'd0);
      chk("t1_flush", 32'(flush), 32'h1E);
      chk("t1_stall", 32'(stall), 32'd0);
      chk("t1_busy", 32'(busy), 32'd1);
      checkOutput(); tick();
      chk("t2_stall", 32'(stall), 32'h03);
      checkOutput(); tick();
      chk("t3_stall", 32'(stall), 32'h03);
      checkOutput(); tick();
      chk("t4_busy", 32'(busy), 32'd0);
      checkOutput(); tick();

      // Flush alongside a stall request, then a re-flush from DRAIN.
      applyStimulus(1'b0, 3'b100, 1'b1, 3'd2);
      checkOutput(); tick();
      applyStimulus(1'b0, 3'b100, 1'b0, 3'd0);
      chk("prio_flush", 32'(flush), 32'h06);
      chk("prio_stall", 32'(stall), 32'd0);
      checkOutput(); tick();
      chk("drain_or_stall", 32'(stall), 32'h0F);
      checkOutput(); tick();
      applyStimulus(1'b0, 3'b000, 1'b1, 3'd5);
      checkOutput(); tick();
      applyStimulus(1'b0, 3'b000, 1'b0, 3'd0);
      chk("reflush_flush", 32'(flush), 32'h3E);
      checkOutput(); tick();
      chk("redrain1_busy", 32'(busy), 32'd1);
      checkOutput(); tick();
      chk("redrain2_stall", 32'(stall), 32'h03);
      checkOutput(); tick();
      chk("redrain_done", 32'(busy), 32'd0);
      checkOutput(); tick();

      // Watchdog: ten consecutive stalled cycles from a clean reset.
      applyStimulus(1'b1, 3'b000, 1'b0, 3'd0);
      tick();
      applyStimulus(1'b0, 3'b001, 1'b0, 3'd0);
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk("wd_flag", 32'(stall_timeout), 32'(k >= TO));
         checkOutput();
      end
      applyStimulus(1'b0, 3'b000, 1'b0, 3'd0);
      tick();
      chk("wd_sticky", 32'(stall_timeout), 32'd1);
      chk("wd_cycles", stall_cycles, 32'd10);
      checkOutput();

      // Reset while draining.
      applyStimulus(1'b0, 3'b000, 1'b1, 3'd3);
      tick();
      applyStimulus(1'b0, 3'b000, 1'b0, 3'd0);
      tick();
      chk("pre_rst_busy", 32'(busy), 32'd1);
      applyStimulus(1'b1, 3'b000, 1'b0, 3'd0);
      checkOutput(); tick();
      applyStimulus(1'b0, 3'b000, 1'b0, 3'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_stall", 32'(stall), 32'd0);
      chk("post_rst_cycles", stall_cycles, 32'd0);
      chk("post_rst_to", 32'(stall_timeout), 32'd0);
      checkOutput(); tick();

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         applyStimulus(($urandom_range(0, 59) == 0), 3'($urandom_range(0, 7)),
                       ($urandom_range(0, 5) == 0), 3'($urandom_range(0, 7)));
         checkOutput();
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
